tof_measure_ctrl: RTL and testbench

Sequencer for one rangefinder time-of-flight shot, sitting beside trigger_pulse_gen.
- On a start request, latches the threshold/direction configuration it drives into trigger_pulse_gen and fires the laser pulse.
- Blanks near-field ringing, then listens for the trigger pulse and reports elapsed cycles as the TOF result.
- Reports timeout when no echo arrives within the range window.

---
 rtl/tof_pkg.sv | 15 +
 rtl/tof_edge_det.sv | 20 ++
 rtl/tof_measure_ctrl.sv | 145 ++++++++++++++
 tb/tb_tof_measure_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_pkg.sv
// Shared state encoding and constants for the time-of-flight shot sequencer.
package tof_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRE   = 3'd1,
        BLANK  = 3'd2,
        LISTEN = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int         ECHO_CNT_W = 4;
    localparam logic [7:0] THRESH_RST = 8'd255;

endpackage

// File: rtl/tof_edge_det.sv
// Rising-edge detector on the trigger_pulse_gen output, qualified by a listen window.
module tof_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger_in,
    input  logic enable,
    output logic echo
);

    logic trig_d;

    // Samples in every state so a trigger already high when the window opens is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) trig_d <= 1'b0;
        else        trig_d <= trigger_in;
    end

    assign echo = enable & trigger_in & ~trig_d;

endmodule

// File: rtl/tof_measure_ctrl.sv
// Single-shot time-of-flight sequencer: fire, blank, listen for echo, report count.
// Build option LAST_ECHO_EN: listen over the full range, also report last echo and echo count.
//
// state  | meaning
// IDLE   | waiting for start, config latched on start
// FIRE   | laser_fire high for FIRE_LEN cycles
// BLANK  | near-field ringing, triggers ignored
// LISTEN | gate_en high, looking for trigger edges
// DONE   | result_valid strobe, back to IDLE
module tof_measure_ctrl
    import tof_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FIRE_LEN  = 10,
    parameter int BLANK_LEN = 20,
    parameter int MAX_RANGE = 4000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            threshold_cfg,
    input  logic                  direction_cfg,
    input  logic                  trigger_in,
    output logic [7:0]            threshold_out,
    output logic                  direction_out,
    output logic                  laser_fire,
    output logic                  gate_en,
    output logic                  busy,
    output logic                  result_valid,
    output logic [CNT_W-1:0]      tof,
    output logic                  timeout,
    output logic [CNT_W-1:0]      tof_last,
    output logic [ECHO_CNT_W-1:0] echo_cnt
);

    localparam logic [CNT_W-1:0] FIRE_END  = CNT_W'(FIRE_LEN - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(FIRE_LEN + BLANK_LEN - 1);
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MAX_RANGE - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             echo;
    logic             at_limit;
    logic             start_shot;
    logic             finish;
    logic [CNT_W-1:0] tof_res;
    logic             timeout_res;

    assign at_limit   = (cnt == LIMIT);
    assign start_shot = (state == IDLE) && (state_nxt == FIRE);
    assign finish     = (state == LISTEN) && (state_nxt == DONE);

    tof_edge_det u_edge_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger_in (trigger_in),
        .enable     (state == LISTEN),
        .echo       (echo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = FIRE;
            FIRE:   if (cnt == FIRE_END) state_nxt = BLANK;
            BLANK:  if (cnt == BLANK_END) state_nxt = LISTEN;
`ifdef LAST_ECHO_EN
            LISTEN: if (at_limit) state_nxt = DONE;
`else
            LISTEN: if (echo || at_limit) state_nxt = DONE;
`endif
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            threshold_out <= THRESH_RST;
            direction_out <= 1'b1;
            laser_fire    <= 1'b0;
            gate_en       <= 1'b0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            tof           <= '0;
            timeout       <= 1'b0;
        end else begin
            laser_fire   <= (state_nxt == FIRE);
            gate_en      <= (state_nxt == LISTEN);
            busy         <= (state_nxt != IDLE);
            result_valid <= (state_nxt == DONE);
            if (start_shot) begin
                threshold_out <= threshold_cfg;
                direction_out <= direction_cfg;
                cnt           <= '0;
            end else if ((state == FIRE || state == BLANK || state == LISTEN) && !at_limit) begin
                cnt <= cnt + 1'b1;
            end
            if (finish) begin
                tof     <= tof_res;
                timeout <= timeout_res;
            end
        end
    end

`ifdef LAST_ECHO_EN
    logic [CNT_W-1:0] first_q, last_q;

    assign tof_res     = (echo_cnt != '0) ? first_q : cnt;
    assign timeout_res = !(echo || (echo_cnt != '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q  <= '0;
            last_q   <= '0;
            echo_cnt <= '0;
            tof_last <= '0;
        end else begin
            if (start_shot) begin
                echo_cnt <= '0;
            end else if (echo) begin
                if (echo_cnt == '0) first_q <= cnt;
                last_q <= cnt;
                if (echo_cnt != '1) echo_cnt <= echo_cnt + 1'b1;
            end
            if (finish) tof_last <= echo ? cnt : ((echo_cnt != '0) ? last_q : cnt);
        end
    end
`else
    assign tof_res     = cnt;
    assign timeout_res = !echo;
    assign tof_last    = '0;
    assign echo_cnt    = '0;
`endif

endmodule

// File: tb/tb_tof_measure_ctrl.sv
// Scoreboard bench for tof_measure_ctrl: trigger waveforms indexed by shot count, reference results from edge lists.
module tb_tof_measure_ctrl;

    localparam int CNT_W     = 16;
    localparam int FIRE_LEN  = 10;
    localparam int BLANK_LEN = 20;
    localparam int MAX_RANGE = 4000;
    localparam int FB        = FIRE_LEN + BLANK_LEN;

    typedef struct {
        longint tof;
        longint timeout;
        longint tof_last;
        longint ecnt;
        longint done_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [7:0]       threshold_cfg = 8'd0;
    logic             direction_cfg = 1'b0;
    logic             trigger_in = 1'b0;
    logic [7:0]       threshold_out;
    logic             direction_out;
    logic             laser_fire;
    logic             gate_en;
    logic             busy;
    logic             result_valid;
    logic [CNT_W-1:0] tof;
    logic             timeout;
    logic [CNT_W-1:0] tof_last;
    logic [3:0]       echo_cnt;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint held_tof = 0;
    bit     wave [0:MAX_RANGE-1];
    exp_t   sb [$];
    exp_t   mon_e;
    logic [7:0] cur_thr;
    logic       cur_dir;

    tof_measure_ctrl #(
        .CNT_W(CNT_W), .FIRE_LEN(FIRE_LEN), .BLANK_LEN(BLANK_LEN), .MAX_RANGE(MAX_RANGE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .threshold_cfg(threshold_cfg), .direction_cfg(direction_cfg), .trigger_in(trigger_in),
        .threshold_out(threshold_out), .direction_out(direction_out), .laser_fire(laser_fire),
        .gate_en(gate_en), .busy(busy), .result_valid(result_valid), .tof(tof),
        .timeout(timeout), .tof_last(tof_last), .echo_cnt(echo_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input longint base);
        int   echoes [$];
        exp_t r;
        for (int c = FB; c < MAX_RANGE; c++)
            if (wave[c] && !wave[c-1]) echoes.push_back(c);
`ifdef LAST_ECHO_EN
        r.done_cyc = base + MAX_RANGE;
        if (echoes.size() == 0) begin
            r.tof = MAX_RANGE - 1; r.tof_last = MAX_RANGE - 1; r.timeout = 1; r.ecnt = 0;
        end else begin
            r.tof      = echoes[0];
            r.tof_last = echoes[echoes.size()-1];
            r.timeout  = 0;
            r.ecnt     = (echoes.size() > 15) ? 15 : echoes.size();
        end
`else
        r.tof_last = 0;
        r.ecnt     = 0;
        if (echoes.size() == 0) begin
            r.tof = MAX_RANGE - 1; r.timeout = 1; r.done_cyc = base + MAX_RANGE;
        end else begin
            r.tof = echoes[0]; r.timeout = 0; r.done_cyc = base + echoes[0] + 1;
        end
`endif
        return r;
    endfunction

    task automatic clear_wave();
        for (int i = 0; i < MAX_RANGE; i++) wave[i] = 1'b0;
    endtask

    task automatic add_pulse(input int s, input int w);
        for (int i = s; i < s + w && i < MAX_RANGE; i++) wave[i] = 1'b1;
    endtask

    // Called at a falling edge while the DUT is idle; returns at a falling edge in IDLE.
    task automatic run_shot(input logic [7:0] thr, input logic dir, input int abort_at, input int start_at);
        longint base;
        bit     done;
        int     k;
        base = cyc + 1;
        if (abort_at < 0) sb.push_back(model(base));
        threshold_cfg = thr;
        direction_cfg = dir;
        trigger_in    = 1'b0;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        threshold_cfg = thr ^ 8'h5A;
        direction_cfg = ~dir;
        check("threshold_latched", threshold_out, thr);
        check("direction_latched", direction_out, dir);
        check("busy_in_fire", busy, 1);
        cur_thr = thr;
        cur_dir = dir;
        done = 0;
        k = 0;
        while (!done && k < MAX_RANGE + 8) begin
            trigger_in = (k < MAX_RANGE) ? wave[k] : 1'b0;
            start      = (k == start_at);
            if (k == start_at) begin
                threshold_cfg = 8'($urandom);
                direction_cfg = ~dir;
            end
            abort = (k == abort_at);
            if (abort_at < 0 || k <= abort_at) begin
                if (k == 0)            check("laser_first", laser_fire, 1);
                if (k == FIRE_LEN - 1) check("laser_last", laser_fire, 1);
                if (k == FIRE_LEN)     check("laser_off", laser_fire, 0);
                if (k == FB - 1)       check("gate_before", gate_en, 0);
                if (k == FB)           check("gate_open", gate_en, 1);
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                check("abort_busy", busy, 0);
                check("abort_gate", gate_en, 0);
                check("abort_laser", laser_fire, 0);
                check("abort_tof_held", tof, held_tof);
                done = 1;
            end else if (result_valid) begin
                done = 1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL shot_bound: no result or abort after %0d cycles, expected completion", k);
        end else if (abort_at < 0) begin
            @(negedge clk);
            trigger_in = 1'b0;
            check("busy_after_done", busy, 0);
            check("valid_one_cycle", result_valid, 0);
            check("threshold_kept", threshold_out, cur_thr);
        end
        trigger_in = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: result_valid=1 tof=%0d, expected no result", tof);
            end else begin
                mon_e = sb.pop_front();
                check("tof", tof, mon_e.tof);
                check("timeout", timeout, mon_e.timeout);
                check("tof_last", tof_last, mon_e.tof_last);
                check("echo_cnt", echo_cnt, mon_e.ecnt);
                check("done_cycle", cyc, mon_e.done_cyc);
                held_tof = mon_e.tof;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        int ab;
        repeat (3) @(negedge clk);
        check("rst_threshold", threshold_out, 255);
        check("rst_direction", direction_out, 1);
        check("rst_busy", busy, 0);
        check("rst_laser", laser_fire, 0);
        check("rst_gate", gate_en, 0);
        check("rst_valid", result_valid, 0);
        check("rst_tof", tof, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        cur_thr = 8'd255;
        cur_dir = 1'b1;

        clear_wave(); add_pulse(150, 3);
        run_shot(8'd220, 1'b1, -1, -1);
        clear_wave();
        run_shot(8'd17, 1'b0, -1, -1);
        clear_wave(); add_pulse(20, 41); add_pulse(200, 2);
        run_shot(8'd90, 1'b1, -1, -1);
        clear_wave(); add_pulse(60, 2);
        run_shot(8'd45, 1'b0, 50, 5);

        abort = 1'b1; start = 1'b1; threshold_cfg = 8'h11; direction_cfg = ~cur_dir;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_beats_start_busy", busy, 0);
        check("abort_beats_start_thr", threshold_out, cur_thr);
        check("abort_beats_start_dir", direction_out, cur_dir);

        clear_wave(); add_pulse(30, 2);
        run_shot(8'd5, 1'b1, -1, -1);
        clear_wave(); add_pulse(25, 10); add_pulse(300, 1);
        run_shot(8'd6, 1'b0, -1, 12);
        clear_wave(); add_pulse(MAX_RANGE - 1, 1);
        run_shot(8'd7, 1'b1, -1, -1);
        clear_wave(); add_pulse(100, 2); add_pulse(300, 4); add_pulse(900, 1);
        run_shot(8'd8, 1'b0, -1, -1);

        for (int n = 0; n < 7; n++) begin
            clear_wave();
            for (int b = 0; b < int'($urandom_range(0, 3)); b++)
                add_pulse(int'($urandom_range(5, 28)), int'($urandom_range(1, 4)));
            mode = int'($urandom_range(0, 2));
            case (mode)
                0: add_pulse(int'($urandom_range(31, 1200)), int'($urandom_range(1, 5)));
                1: begin
                    add_pulse(int'($urandom_range(20, 29)), int'($urandom_range(5, 60)));
                    add_pulse(int'($urandom_range(100, 1500)), int'($urandom_range(1, 3)));
                end
                default:
                    for (int p = 0; p < 3; p++)
                        add_pulse(int'($urandom_range(30, 1500)), int'($urandom_range(1, 3)));
            endcase
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 28)) : -1;
            run_shot(8'($urandom), 1'($urandom), ab,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 25)) : -1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
